rx_buffer: RTL and testbench



---
 rtl/rx_buffer.sv | 166 ++++++++++++++++
 tb/tb_rx_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_buffer.sv
// ============================================================================
// Module  : rx_buffer (with pcie_pkg record type)
// Brief   : Receive record FIFO with FWFT output and credit-advertisement FSM.
//           Optional macro RX_BUFFER_STATS_EN adds o_drop_count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_pkg;
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] data;
    } tx_buffer_record;
endpackage

module rx_buffer
    import pcie_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int NUM_LANES    = 4,
    parameter int CREDIT_BATCH = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_wren,
    input  tx_buffer_record [0:NUM_LANES/4-1]     i_rbr,
    input  logic                                  i_ren,
    output logic                                  o_valid,
    output tx_buffer_record [0:NUM_LANES/4-1]     o_rbr,
    output logic                                  o_empty,
    output logic                                  o_overflow,
    output logic                                  o_fc_valid,
    output logic [$clog2(DEPTH+1)-1:0]            o_fc_credits,
`ifdef RX_BUFFER_STATS_EN
    output logic [15:0]                           o_drop_count,
`endif
    input  logic                                  i_fc_ack
);

    localparam int NR = NUM_LANES / 4;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ADV  = 2'd2
    } state_t;

    tx_buffer_record [0:NR-1] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_empty;
    logic          r_overflow;
    logic [CW-1:0] r_pending;
    logic [CW-1:0] r_fc_credits;
    state_t        r_state;

    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_pend_inc;
    logic [CW-1:0] w_pend_nxt;
    logic          w_latch;
    logic [CW-1:0] w_latch_val;
    state_t        w_state_nxt;

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_pop       = i_ren && (r_count != '0);
    assign w_push      = i_wren && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_drop      = i_wren && !w_push;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_pend_inc  = (w_pop && (r_pending != CW'(DEPTH))) ? r_pending + CW'(1) : r_pending;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rbr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_empty <= (w_count_nxt == '0);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_latch_val = r_pending;
        w_pend_nxt  = w_pend_inc;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_ADV;
                w_latch     = 1'b1;
                w_latch_val = CW'(DEPTH);
            end
            ST_IDLE: begin
                // Flush a partial batch once the FIFO drains so no credit is stranded.
                if ((r_pending >= CW'(CREDIT_BATCH)) ||
                    ((r_pending != '0) && (r_count == '0))) begin
                    w_state_nxt = ST_ADV;
                    w_latch     = 1'b1;
                    w_latch_val = r_pending;
                    w_pend_nxt  = CW'(w_pop);
                end
            end
            ST_ADV: begin
                if (i_fc_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_pending    <= '0;
            r_fc_credits <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pend_nxt;
            if (w_latch) r_fc_credits <= w_latch_val;
        end
    end

`ifdef RX_BUFFER_STATS_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

    assign o_valid      = r_valid;
    assign o_empty      = r_empty;
    assign o_rbr        = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_overflow   = r_overflow;
    assign o_fc_valid   = (r_state == ST_ADV);
    assign o_fc_credits = r_fc_credits;

endmodule

`default_nettype wire

// File: tb/tb_rx_buffer.sv
// ============================================================================
// Module  : tb_rx_buffer
// Brief   : Self-checking bench for rx_buffer: vector table, corner sequences,
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_buffer;
    import pcie_pkg::*;

    localparam int DEPTH = 8;
    localparam int NUM_LANES = 4;
    localparam int CB = 2;
    localparam int NR = NUM_LANES / 4;

    typedef tx_buffer_record [0:NR-1] entry_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wren = 1'b0;
    entry_t      i_rbr = '0;
    logic        i_ren = 1'b0;
    logic        i_fc_ack = 1'b0;
    logic        o_valid;
    entry_t      o_rbr;
    logic        o_empty;
    logic        o_overflow;
    logic        o_fc_valid;
    logic [3:0]  o_fc_credits;
`ifdef RX_BUFFER_STATS_EN
    logic [15:0] o_drop_count;
`endif

    rx_buffer #(.DEPTH(DEPTH), .NUM_LANES(NUM_LANES), .CREDIT_BATCH(CB)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_wren      (i_wren),
        .i_rbr       (i_rbr),
        .i_ren       (i_ren),
        .o_valid     (o_valid),
        .o_rbr       (o_rbr),
        .o_empty     (o_empty),
        .o_overflow  (o_overflow),
        .o_fc_valid  (o_fc_valid),
        .o_fc_credits(o_fc_credits),
`ifdef RX_BUFFER_STATS_EN
        .o_drop_count(o_drop_count),
`endif
        .i_fc_ack    (i_fc_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: queue contents plus credit bookkeeping.
    entry_t mq[$];
    int     m_pend;
    int     m_st;      // 0 = awaiting first advertisement, 1 = idle, 2 = advertising
    int     m_cred;
    bit     m_ovf;
    int     m_drops;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_st = 0; m_cred = 0; m_ovf = 0; m_drops = 0;
    endtask

    task automatic model_step(input logic wren, input entry_t d, input logic ren, input logic ack);
        int n;
        bit pop, push;
        n    = mq.size();
        pop  = ren && (n > 0);
        push = wren && ((n < DEPTH) || pop);
        if (wren && !push) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end
        if (m_st == 0) begin
            m_cred = DEPTH; m_st = 2; m_pend += int'(pop);
        end else if (m_st == 1) begin
            if (m_pend >= CB || (m_pend > 0 && n == 0)) begin
                m_cred = m_pend; m_pend = int'(pop); m_st = 2;
            end else begin
                m_pend += int'(pop);
            end
        end else begin
            if (ack) m_st = 1;
            m_pend += int'(pop);
        end
        if (m_pend > DEPTH) m_pend = DEPTH;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
    endtask

    task automatic check_model();
        entry_t head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("m_valid", 64'(o_valid), 64'(mq.size() > 0));
        chk("m_rbr", 64'(o_rbr), 64'(head));
        chk("m_empty", 64'(o_empty), 64'(mq.size() == 0));
        chk("m_ovf", 64'(o_overflow), 64'(m_ovf));
        chk("m_fcv", 64'(o_fc_valid), 64'(m_st == 2));
        chk("m_cred", 64'(o_fc_credits), 64'(m_cred));
`ifdef RX_BUFFER_STATS_EN
        chk("m_drops", 64'(o_drop_count), 64'(m_drops));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_rbr"}, 64'(o_rbr), 64'd0);
        chk({tag, "_empty"}, 64'(o_empty), 64'd1);
        chk({tag, "_ovf"}, 64'(o_overflow), 64'd0);
        chk({tag, "_fcv"}, 64'(o_fc_valid), 64'd0);
        chk({tag, "_cred"}, 64'(o_fc_credits), 64'd0);
`ifdef RX_BUFFER_STATS_EN
        chk({tag, "_drops"}, 64'(o_drop_count), 64'd0);
`endif
    endtask

    // Drive one cycle of inputs, advance one edge, then compare against the model.
    task automatic cycle(input logic wren, input entry_t d, input logic ren, input logic ack);
        i_wren = wren; i_rbr = d; i_ren = ren; i_fc_ack = ack;
        @(posedge clk);
        model_step(wren, d, ren, ack);
        #1;
        check_model();
    endtask

    typedef struct {
        logic   wren;
        entry_t d;
        logic   ren;
        logic   ack;
        logic   e_valid;
        entry_t e_rbr;
        logic   e_fcv;
        logic [3:0] e_cred;
    } vec_t;

    vec_t tbl[16];

    initial begin
        entry_t ea, eb, ec, ex, ey, ew;
        entry_t wv[8];

        ea = entry_t'(36'h1_0000_00A1);
        eb = entry_t'(36'h2_0000_00B2);
        ec = entry_t'(36'h3_0000_00C3);
        ex = entry_t'(36'hE_DEAD_BEEF);
        ey = entry_t'(36'h5_1234_5678);
        for (int i = 0; i < 8; i++) wv[i] = entry_t'({4'(i), 32'hF00D_0000 + 32'(i)});

        tbl[0]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd8};
        tbl[1]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd8};
        tbl[2]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd8};
        tbl[3]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd8};
        tbl[4]  = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd8};
        tbl[5]  = '{1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd8};
        tbl[6]  = '{1'b1, ea, 1'b0, 1'b0, 1'b1, ea, 1'b0, 4'd8};
        tbl[7]  = '{1'b1, eb, 1'b0, 1'b0, 1'b1, ea, 1'b0, 4'd8};
        tbl[8]  = '{1'b1, ec, 1'b0, 1'b0, 1'b1, ea, 1'b0, 4'd8};
        tbl[9]  = '{1'b0, '0, 1'b1, 1'b0, 1'b1, eb, 1'b0, 4'd8};
        tbl[10] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, ec, 1'b0, 4'd8};
        tbl[11] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 4'd2};
        tbl[12] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd2};
        tbl[13] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd2};
        tbl[14] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd1};
        tbl[15] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd1};

        // Reset held across two edges, then released away from an edge.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        i_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].wren, tbl[i].d, tbl[i].ren, tbl[i].ack);
            chk($sformatf("t%0d_valid", i), 64'(o_valid), 64'(tbl[i].e_valid));
            chk($sformatf("t%0d_empty", i), 64'(o_empty), 64'(!tbl[i].e_valid));
            chk($sformatf("t%0d_rbr", i), 64'(o_rbr), 64'(tbl[i].e_rbr));
            chk($sformatf("t%0d_fcv", i), 64'(o_fc_valid), 64'(tbl[i].e_fcv));
            chk($sformatf("t%0d_cred", i), 64'(o_fc_credits), 64'(tbl[i].e_cred));
        end

        // Fill, overflow on a write without pop, then write-with-pop while full.
        for (int i = 0; i < 8; i++) cycle(1'b1, wv[i], 1'b0, 1'b0);
        chk("full_rbr", 64'(o_rbr), 64'(wv[0]));
        chk("full_ovf0", 64'(o_overflow), 64'd0);
        cycle(1'b1, ex, 1'b0, 1'b0);
        chk("drop_ovf", 64'(o_overflow), 64'd1);
        chk("drop_rbr", 64'(o_rbr), 64'(wv[0]));
`ifdef RX_BUFFER_STATS_EN
        chk("drop_cnt", 64'(o_drop_count), 64'd1);
`endif
        cycle(1'b1, ey, 1'b1, 1'b0);
        chk("wp_rbr", 64'(o_rbr), 64'(wv[1]));
        for (int i = 2; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            chk($sformatf("drain%0d", i), 64'(o_rbr), 64'(wv[i]));
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("drain_y", 64'(o_rbr), 64'(ey));
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("drain_empty", 64'(o_empty), 64'd1);
        chk("ovf_sticky", 64'(o_overflow), 64'd1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);

        // Interleaved write/read runs the pointers around the ring.
        for (int i = 0; i < 12; i++) begin
            ew = entry_t'({4'(i), $urandom()});
            cycle(1'b1, ew, 1'b0, 1'b1);
            chk($sformatf("wrap_w%0d", i), 64'(o_rbr), 64'(ew));
            cycle(1'b0, '0, 1'b1, 1'b1);
            chk($sformatf("wrap_e%0d", i), 64'(o_empty), 64'd1);
        end

        // Randomized traffic with occasional bias toward filling or draining.
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = ((i / 100) % 2 == 0) ? 75 : 35;
            rp = ((i / 100) % 2 == 0) ? 30 : 70;
            cycle(1'($urandom_range(99) < wp), entry_t'({$urandom(), $urandom()}),
                  1'($urandom_range(99) < rp), 1'($urandom_range(99) < 40));
        end

        // Asynchronous reset mid-stream: outputs must clear without a clock edge.
        for (int i = 0; i < 5; i++) cycle(1'b1, entry_t'({$urandom(), $urandom()}), 1'b0, 1'b0);
        i_rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        model_reset();
        @(negedge clk);
        i_rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("readv_fcv", 64'(o_fc_valid), 64'd1);
        chk("readv_cred", 64'(o_fc_credits), 64'd8);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("readv_ack", 64'(o_fc_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
